// File: rtl/write_queue_pkg.sv
// Shared constants for the write queue register: status word width and status bit positions.
// Imported by write_queue_register and write_queue_storage.
package write_queue_pkg;

  localparam int STATUS_W        = 32;
  localparam int STATUS_EMPTY_BIT = 16;
  localparam int STATUS_FULL_BIT  = 17;
  localparam int STATUS_OVF_BIT   = 18;

endpackage

// File: rtl/write_queue_storage.sv
// DEPTH x DATA_WIDTH entry array for the write queue.
// Synchronous write at the tail pointer, asynchronous read at the head pointer; contents are never reset.
module write_queue_storage
  import write_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PW         = 2
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [PW-1:0]         i_wr_ptr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [PW-1:0]         i_rd_ptr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/write_queue_register.sv
// Processor-to-I/O write queue with polled status word (count/empty/full/overflow).
// Build option: define WRITE_QUEUE_OVERFLOW_FLAG_EN to get the sticky, read-to-clear overflow flag.
module write_queue_register
  import write_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Sys_RegSelect,
  input  logic                  Sys_WrEn,
  input  logic [DATA_WIDTH-1:0] Sys_WrData,
  input  logic                  Sys_RdEn,
  output logic [STATUS_W-1:0]   Sys_StatusData,
  output logic                  IO_Valid,
  output logic [DATA_WIDTH-1:0] IO_Data,
  input  logic                  IO_Ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;
  logic w_pop;
  logic w_push;
  logic w_ovf;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_wr    = Sys_WrEn & Sys_RegSelect;
  assign w_rd    = Sys_RdEn & Sys_RegSelect;
  assign w_pop   = ~w_empty & IO_Ready;
  // A pop in the same cycle frees a slot, so a full queue still accepts the write.
  assign w_push  = w_wr & (~w_full | w_pop);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef WRITE_QUEUE_OVERFLOW_FLAG_EN
  logic w_reject;
  logic r_ovf;

  assign w_reject = w_wr & w_full & ~w_pop;

  // A new overflow beats a concurrent read-clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ovf <= 1'b0;
    end else if (w_reject) begin
      r_ovf <= 1'b1;
    end else if (w_rd) begin
      r_ovf <= 1'b0;
    end
  end

  assign w_ovf = r_ovf;
`else
  // Without the flag a status read has no side effect.
  assign w_ovf = w_rd & 1'b0;
`endif

  write_queue_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PW         (PW)
  ) u_storage (
    .i_clk     (Clock),
    .i_wr_en   (w_push),
    .i_wr_ptr  (r_tail),
    .i_wr_data (Sys_WrData),
    .i_rd_ptr  (r_head),
    .o_rd_data (IO_Data)
  );

  assign IO_Valid = ~w_empty;

  always_comb begin
    Sys_StatusData                   = '0;
    Sys_StatusData[CW-1:0]           = r_count;
    Sys_StatusData[STATUS_EMPTY_BIT] = w_empty;
    Sys_StatusData[STATUS_FULL_BIT]  = w_full;
    Sys_StatusData[STATUS_OVF_BIT]   = w_ovf;
  end

endmodule
